// File: rtl/cache_line_refill_pkg.sv
// Shared types and address helpers for the cache line refill engine.
// Address layout: [15:8] tag, [7:4] index, [3:2] word offset, [1:0] byte offset.
package cache_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int DATA_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int INDEX_WIDTH    = 4;
    localparam int TAG_WIDTH      = 8;
    localparam int OFFSET_WIDTH   = 2;
    localparam int BYTE_OFF_WIDTH = 2;
    localparam int LINE_DATA_W    = WORDS_PER_LINE * DATA_WIDTH;
    localparam int LINE_WIDTH     = 1 + TAG_WIDTH + LINE_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } refill_state_t;

    typedef struct packed {
        logic                                      valid;
        logic [TAG_WIDTH-1:0]                      tag;
        logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] data;
    } cache_line_t;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[BYTE_OFF_WIDTH+OFFSET_WIDTH +: INDEX_WIDTH];
    endfunction

    function automatic logic [OFFSET_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] addr);
        return addr[BYTE_OFF_WIDTH +: OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/cache_line_refill_buffer.sv
// Four-word line buffer: written one word per beat by offset, cleared when a refill starts.
module refill_line_buffer
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_we,
    input  logic [OFFSET_WIDTH-1:0] i_slot,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [LINE_DATA_W-1:0]  o_line
);

    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] r_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
        end else if (i_clear) begin
            r_words <= '0;
        end else if (i_we) begin
            r_words[i_slot] <= i_wdata;
        end
    end

    assign o_line = r_words;

endmodule

// File: rtl/cache_line_refill.sv
// Read-miss refill FSM: fetches a 4-word line one word at a time and writes it to the cache.
// Optional macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN fetches the missed word first.
module cache_line_refill
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   miss_req,
    input  logic [ADDR_WIDTH-1:0]  miss_addr,
    output logic                   stall,
    output logic                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]  mem_rsp_data,
    output logic                   fill_we,
    output logic [INDEX_WIDTH-1:0] fill_index,
    output logic [LINE_WIDTH-1:0]  fill_line,
    output logic                   crit_valid,
    output logic [DATA_WIDTH-1:0]  crit_data
);

    refill_state_t r_state, w_next;

    logic [TAG_WIDTH-1:0]    r_tag;
    logic [INDEX_WIDTH-1:0]  r_index;
    logic [OFFSET_WIDTH-1:0] r_moff;
    logic [OFFSET_WIDTH-1:0] r_beat;

    logic                                      w_start;
    logic                                      w_consume;
    logic [OFFSET_WIDTH-1:0]                   w_beat_off;
    logic [LINE_DATA_W-1:0]                    w_buf;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] w_words;
    cache_line_t                               w_line;

    assign w_start   = (r_state == ST_IDLE) && miss_req;
    assign w_consume = (r_state == ST_WAIT) && mem_rsp_valid;

    // Offset arithmetic is 2 bits wide, so it wraps inside the line and never reaches the index.
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign w_beat_off = r_moff + r_beat;
`else
    assign w_beat_off = r_beat;
`endif

    assign w_words = w_buf;
    assign w_line  = {1'b1, r_tag, w_words};

    refill_line_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_we    (w_consume),
        .i_slot  (w_beat_off),
        .i_wdata (mem_rsp_data),
        .o_line  (w_buf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag   <= '0;
            r_index <= '0;
            r_moff  <= '0;
            r_beat  <= '0;
        end else if (w_start) begin
            r_tag   <= addr_tag(miss_addr);
            r_index <= addr_index(miss_addr);
            r_moff  <= addr_offset(miss_addr);
            r_beat  <= '0;
        end else if (w_consume) begin
            r_beat  <= r_beat + 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        stall         = (r_state != ST_IDLE);
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        fill_we       = 1'b0;
        fill_index    = '0;
        fill_line     = '0;
        crit_valid    = 1'b0;
        crit_data     = '0;
        case (r_state)
            ST_IDLE: begin
                if (miss_req) w_next = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {r_tag, r_index, w_beat_off, {BYTE_OFF_WIDTH{1'b0}}};
                if (mem_req_ready) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    w_next = (r_beat == OFFSET_WIDTH'(WORDS_PER_LINE - 1)) ? ST_FILL : ST_REQ;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                    if (r_beat == '0) begin
                        crit_valid = 1'b1;
                        crit_data  = mem_rsp_data;
                    end
`endif
                end
            end
            ST_FILL: begin
                fill_we    = 1'b1;
                fill_index = r_index;
                fill_line  = w_line;
                w_next     = ST_IDLE;
`ifndef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                crit_valid = 1'b1;
                crit_data  = w_words[r_moff];
`endif
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
